// File: rtl/x_candidate_gen_if.sv
// Candidate stream from the enumerator to the F stage, plus the F stage's result strobe.
// x_tvalid is a one-cycle qualifier with no ready: the source only issues while it holds a credit,
// and each f_done pulse from the sink hands one credit back.
interface x_candidate_gen_if #(
    parameter int J = 14,
    parameter int A = 2
);
    localparam int AWIDTH = $clog2(A) + 1;
    localparam int IDX_W  = J * $clog2(A);

    logic [J*AWIDTH-1:0] x;
    logic                x_tvalid;
    logic [IDX_W-1:0]    x_index;
    logic                x_last;
    logic                f_done;

    modport master (output x, x_tvalid, x_index, x_last, input f_done);
    modport slave  (input x, x_tvalid, x_index, x_last, output f_done);
endinterface

// File: rtl/x_candidate_gen.sv
// Enumerates all A^J candidate vectors under credit-based throttling toward the F stage.
// Optional macro X_GEN_ABORT_EN adds an abort input that stops issuing and drains outstanding credits.
module x_candidate_gen #(
    parameter int J       = 14,
    parameter int A       = 2,
    parameter int CREDITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef X_GEN_ABORT_EN
    input  logic              abort,
`endif
    x_candidate_gen_if.master xs,
    output logic              busy,
    output logic              done,
    output logic              credit_err,
    output logic [1:0]        fsm_state
);
    localparam int DW     = $clog2(A);
    localparam int AWIDTH = DW + 1;
    localparam int IDX_W  = J * DW;
    localparam int CW     = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_FULL = CW'(CREDITS);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t              state_q, state_nxt;
    logic [IDX_W-1:0]    digits_q, digits_nxt, digits_base;
    logic [CW-1:0]       credits_q, credits_nxt, credit_base;
    logic [J*AWIDTH-1:0] x_q, x_nxt;
    logic [IDX_W-1:0]    idx_q, idx_nxt;
    logic                tvalid_q, tvalid_nxt;
    logic                last_q, last_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                err_q, err_nxt;
    logic                issue;
    logic                abort_req;

`ifdef X_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Element value 2*d-(A-1) equals {d,1} with its MSB flipped, since A is a power of two.
    function automatic logic [J*AWIDTH-1:0] map_x(input logic [IDX_W-1:0] d);
        logic [J*AWIDTH-1:0] r;
        logic [AWIDTH-1:0]   e;
        r = '0;
        for (int k = 0; k < J; k++) begin
            e = {d[k*DW +: DW], 1'b1};
            e[AWIDTH-1] = ~e[AWIDTH-1];
            r[k*AWIDTH +: AWIDTH] = e;
        end
        return r;
    endfunction

    always_comb begin
        state_nxt   = state_q;
        digits_base = digits_q;
        credit_base = credits_q;
        issue       = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = err_q;
        tvalid_nxt  = 1'b0;
        last_nxt    = 1'b0;
        x_nxt       = x_q;
        idx_nxt     = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt   = RUN;
                    digits_base = '0;
                    credit_base = CRED_FULL;
                    issue       = 1'b1;
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_nxt = DRAIN;
                end else if (credits_q != '0) begin
                    issue = 1'b1;
                    if (digits_q == '1) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (credits_q == CRED_FULL) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        digits_nxt = digits_base;
        if (issue) begin
            tvalid_nxt = 1'b1;
            x_nxt      = map_x(digits_base);
            idx_nxt    = digits_base;
            last_nxt   = (digits_base == '1);
            digits_nxt = digits_base + IDX_W'(1);
        end

        // A return with nothing outstanding is dropped and flagged rather than overflowing.
        credits_nxt = credit_base;
        if (issue && !xs.f_done) begin
            credits_nxt = credit_base - CW'(1);
        end else if (!issue && xs.f_done) begin
            if (credit_base == CRED_FULL) err_nxt = 1'b1;
            else credits_nxt = credit_base + CW'(1);
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            digits_q  <= '0;
            credits_q <= CRED_FULL;
            x_q       <= '0;
            idx_q     <= '0;
            tvalid_q  <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            digits_q  <= digits_nxt;
            credits_q <= credits_nxt;
            x_q       <= x_nxt;
            idx_q     <= idx_nxt;
            tvalid_q  <= tvalid_nxt;
            last_q    <= last_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    assign xs.x        = x_q;
    assign xs.x_tvalid = tvalid_q;
    assign xs.x_index  = idx_q;
    assign xs.x_last   = last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign credit_err  = err_q;
    assign fsm_state   = state_q;
endmodule

// File: tb/tb_x_candidate_gen.sv
// Directed bench for x_candidate_gen: J=3/A=2 instance for the main scenarios, J=2/A=4 for the radix-4 run.
module tb_x_candidate_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
`ifdef X_GEN_ABORT_EN
    logic abort_a = 1'b0;
    logic abort_b = 1'b0;
`endif
    logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [1:0] st_a, st_b;

    always #5 clk = ~clk;

    x_candidate_gen_if #(.J(3), .A(2)) xa ();
    x_candidate_gen_if #(.J(2), .A(4)) xb ();

    x_candidate_gen #(.J(3), .A(2), .CREDITS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
`ifdef X_GEN_ABORT_EN
        .abort(abort_a),
`endif
        .xs(xa), .busy(busy_a), .done(done_a), .credit_err(err_a), .fsm_state(st_a)
    );

    x_candidate_gen #(.J(2), .A(4), .CREDITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
`ifdef X_GEN_ABORT_EN
        .abort(abort_b),
`endif
        .xs(xb), .busy(busy_b), .done(done_b), .credit_err(err_b), .fsm_state(st_b)
    );

    typedef struct {
        int         idx;
        logic [5:0] exp_x;
        logic       exp_last;
    } vec_t;

    vec_t vec_tab [8];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_vec, n_done, n_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        xa.f_done = 1'b0;
        xb.f_done = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Returns f_done three edges after each x_tvalid and checks every vector against vec_tab.
    task automatic run_resp(input int max_cyc, input int stop_idx);
        logic [2:0] hist;
        hist = '0;
        n_vec = 0;
        n_done = 0;
        n_last = 0;
        for (int c = 0; c < max_cyc; c++) begin
            if (xa.x_tvalid) begin
                if (n_vec < 8) begin
                    check("a_x_index", 32'(xa.x_index), vec_tab[n_vec].idx);
                    check("a_x", 32'(xa.x), 32'(vec_tab[n_vec].exp_x));
                    check("a_x_last", 32'(xa.x_last), 32'(vec_tab[n_vec].exp_last));
                end
                n_vec++;
                if (xa.x_last) n_last++;
            end
            if (done_a) n_done++;
            if (stop_idx >= 0 && xa.x_tvalid && int'(xa.x_index) == stop_idx) return;
            hist = {hist[1:0], xa.x_tvalid};
            xa.f_done = hist[2];
            step();
        end
        xa.f_done = 1'b0;
    endtask

    function automatic logic [5:0] model_b(input int n);
        logic [5:0] r;
        int d, v;
        r = '0;
        for (int k = 0; k < 2; k++) begin
            d = (n >> (2 * k)) & 3;
            v = 2 * d - 3;
            r[k*3 +: 3] = 3'(v);
        end
        return r;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, last_idx, nb;
        logic [3:0] hb;
        // element k = d_k ? 2'b01 : 2'b11, element 0 in the LSBs
        vec_tab[0] = '{0, 6'b111111, 1'b0};
        vec_tab[1] = '{1, 6'b111101, 1'b0};
        vec_tab[2] = '{2, 6'b110111, 1'b0};
        vec_tab[3] = '{3, 6'b110101, 1'b0};
        vec_tab[4] = '{4, 6'b011111, 1'b0};
        vec_tab[5] = '{5, 6'b011101, 1'b0};
        vec_tab[6] = '{6, 6'b010111, 1'b0};
        vec_tab[7] = '{7, 6'b010101, 1'b1};
        xa.f_done = 1'b0;
        xb.f_done = 1'b0;

        do_reset();
        check("rst_x_tvalid", 32'(xa.x_tvalid), 0);
        check("rst_x", 32'(xa.x), 0);
        check("rst_x_index", 32'(xa.x_index), 0);
        check("rst_x_last", 32'(xa.x_last), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_credit_err", 32'(err_a), 0);
        check("rst_state", 32'(st_a), 0);

        // Full enumeration with returning credits
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("t1_busy", 32'(busy_a), 1);
        run_resp(60, -1);
        check("t1_vec_count", n_vec, 8);
        check("t1_last_count", n_last, 1);
        check("t1_done_count", n_done, 1);
        check("t1_credit_err", 32'(err_a), 0);
        check("t1_busy_end", 32'(busy_a), 0);

        // Stray f_done in IDLE: sticky error across a full run, cleared by reset
        xa.f_done = 1'b1;
        step();
        xa.f_done = 1'b0;
        step();
        check("t4_err_set", 32'(err_a), 1);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        run_resp(60, -1);
        check("t4_vec_count", n_vec, 8);
        check("t4_done_count", n_done, 1);
        check("t4_err_sticky", 32'(err_a), 1);
        do_reset();
        check("t4_err_cleared", 32'(err_a), 0);

        // No returns: exactly two issues, then one return releases idx 2
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        cnt = 0;
        last_idx = -1;
        for (int c = 0; c < 8; c++) begin
            if (xa.x_tvalid) begin
                cnt++;
                last_idx = int'(xa.x_index);
            end
            step();
        end
        check("t2_stall_count", cnt, 2);
        check("t2_stall_last_idx", last_idx, 1);
        xa.f_done = 1'b1;
        step();
        xa.f_done = 1'b0;
        check("t2_no_issue_on_return_edge", 32'(xa.x_tvalid), 0);
        step();
        check("t2_resume_valid", 32'(xa.x_tvalid), 1);
        check("t2_resume_idx", 32'(xa.x_index), 2);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (xa.x_tvalid) cnt++;
        end
        check("t2_stall_again", cnt, 0);
        do_reset();

        // Issue and return on the same edge at one credit: back-to-back issues
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("t3_v0", 32'(xa.x_tvalid), 1);
        check("t3_idx0", 32'(xa.x_index), 0);
        xa.f_done = 1'b1;
        step();
        xa.f_done = 1'b0;
        check("t3_v1", 32'(xa.x_tvalid), 1);
        check("t3_idx1", 32'(xa.x_index), 1);
        step();
        check("t3_v2", 32'(xa.x_tvalid), 1);
        check("t3_idx2", 32'(xa.x_index), 2);
        step();
        check("t3_stall", 32'(xa.x_tvalid), 0);
        check("t3_hold_idx", 32'(xa.x_index), 2);
        do_reset();

        // Reset mid-run after idx 4, then a fresh run from index 0
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        run_resp(60, 4);
        check("t5_reached_idx4", n_vec, 5);
        xa.f_done = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t5_rst_tvalid", 32'(xa.x_tvalid), 0);
        check("t5_rst_x", 32'(xa.x), 0);
        check("t5_rst_index", 32'(xa.x_index), 0);
        check("t5_rst_busy", 32'(busy_a), 0);
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("t5_restart_valid", 32'(xa.x_tvalid), 1);
        check("t5_restart_idx", 32'(xa.x_index), 0);
        run_resp(60, -1);
        check("t5_vec_count", n_vec, 8);
        check("t5_done_count", n_done, 1);
        do_reset();

        // Radix-4 instance: 16 vectors, element value 2*d-3
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        nb = 0;
        cnt = 0;
        hb = '0;
        for (int c = 0; c < 120; c++) begin
            if (xb.x_tvalid) begin
                check("b_x_index", 32'(xb.x_index), nb);
                check("b_x", 32'(xb.x), 32'(model_b(nb)));
                check("b_x_last", 32'(xb.x_last), (nb == 15) ? 1 : 0);
                if (nb == 6) check("b_idx6_x", 32'(xb.x), 32'(6'b111001));
                nb++;
            end
            if (done_b) cnt++;
            hb = {hb[2:0], xb.x_tvalid};
            xb.f_done = hb[2];
            step();
        end
        xb.f_done = 1'b0;
        check("b_vec_count", nb, 16);
        check("b_done_count", cnt, 1);
        check("b_credit_err", 32'(err_b), 0);

`ifdef X_GEN_ABORT_EN
        // Abort after idx 2: nothing more issues, done follows the two outstanding returns
        do_reset();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        xa.f_done = 1'b1;
        step();
        xa.f_done = 1'b0;
        step();
        check("t7_idx2", 32'(xa.x_index), 2);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        cnt = 0;
        n_done = 0;
        for (int c = 0; c < 4; c++) begin
            if (xa.x_tvalid) cnt++;
            if (done_a) n_done++;
            step();
        end
        check("t7_drain_busy", 32'(busy_a), 1);
        check("t7_no_done_early", n_done, 0);
        xa.f_done = 1'b1;
        step();
        step();
        xa.f_done = 1'b0;
        n_last = 0;
        for (int c = 0; c < 6; c++) begin
            if (xa.x_tvalid) cnt++;
            if (xa.x_last) n_last++;
            if (done_a) n_done++;
            step();
        end
        check("t7_no_issue", cnt, 0);
        check("t7_no_last", n_last, 0);
        check("t7_done_count", n_done, 1);
        check("t7_busy_end", 32'(busy_a), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
